// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling stage: mode encodings and the
// signed helper functions used by the per-channel combiner.
// Functions work on a 32-bit signed carrier; callers size-cast the result.
package pool_pkg;

    localparam logic POOL_AVG = 1'b0;
    localparam logic POOL_MAX = 1'b1;

    localparam int CALC_W = 32;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Signed maximum of two values.
    function automatic calc_t smax(input calc_t a, input calc_t b);
        return (a > b) ? a : b;
    endfunction

    // Divide a 4-sample sum by 4, rounding half toward +inf.
    function automatic calc_t round_shr2(input calc_t s);
        calc_t t;
        t = s + 32'sd2;
        return t >>> 2;
    endfunction

endpackage

// File: rtl/pool_combine.sv
// Per-channel combiner: pair stage (h with x) or window stage (line buffer with p).
// Ports: i_a/i_b DATA_W+1-bit signed operands, i_mode avg/max, i_final selects the
//        window stage (rounding divide and ReLU), o_y OUT_W-bit signed result.
module pool_combine
    import pool_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int OUT_W  = DATA_W + 1
)(
    input  logic signed [DATA_W:0]  i_a,
    input  logic signed [DATA_W:0]  i_b,
    input  logic                    i_mode,
    input  logic                    i_final,
    input  logic                    i_relu_en,
    output logic signed [OUT_W-1:0] o_y
);

    localparam int PW = DATA_W + 1;
    localparam int SW = DATA_W + 2;

    logic signed [SW-1:0] w_sum;
    logic signed [PW-1:0] w_max;
    logic signed [PW-1:0] w_avg;
    logic signed [PW-1:0] w_res;

    assign w_sum = SW'(i_a) + SW'(i_b);
    assign w_max = PW'(smax(calc_t'(i_a), calc_t'(i_b)));

    always_comb begin
        // In the pair stage both operands are sign-extended DATA_W samples,
        // so their sum always fits in DATA_W+1 bits.
        w_avg = w_sum[PW-1:0];
        if (i_final) begin
            w_avg = PW'(round_shr2(calc_t'(w_sum)));
        end
        w_res = (i_mode == POOL_MAX) ? w_max : w_avg;
        if (i_final && i_relu_en && (w_res < 0)) begin
            w_res = '0;
        end
        // A window result is always within DATA_W bits, so truncation is safe.
        o_y = OUT_W'(w_res);
    end

endmodule

// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 average/max pooling over a raster stream of CHANNELS samples.
// Ports: valid_in/data_in pixel in, mode/relu_en config (latched at pixel 0,0),
//        data_out/valid_out pooled pixel (1 cycle after 4th window pixel), frame_done.
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int DATA_W   = 12,
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24,
    parameter int COL_BIT  = $clog2(IMG_W),
    parameter int ROW_BIT  = $clog2(IMG_H)
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    input  logic                         mode,
    input  logic                         relu_en,
    output logic [CHANNELS*DATA_W-1:0]   data_out,
    output logic                         valid_out,
    output logic                         frame_done
);

    localparam int PW     = DATA_W + 1;
    localparam int HALF_W = IMG_W / 2;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_BIT-1:0]       r_col;
    logic [ROW_BIT-1:0]       r_row;
    logic                     r_mode;
    logic                     r_relu;
    logic signed [DATA_W-1:0] r_h  [CHANNELS];
    logic signed [PW-1:0]     r_lb [CHANNELS][HALF_W];

    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_first;
    logic                     w_fire;
    logic [LB_AW-1:0]         w_lb_idx;
    logic signed [DATA_W-1:0] w_x     [CHANNELS];
    logic signed [PW-1:0]     w_x_ext [CHANNELS];
    logic signed [PW-1:0]     w_h_ext [CHANNELS];
    logic signed [PW-1:0]     w_p     [CHANNELS];
    logic signed [DATA_W-1:0] w_w     [CHANNELS];

    assign w_col_last = (r_col == COL_BIT'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_BIT'(IMG_H - 1));
    assign w_first    = (r_col == '0) && (r_row == '0);
    // Fourth pixel of a window: odd row, odd column.
    assign w_fire     = valid_in && r_col[0] && r_row[0];
    assign w_lb_idx   = LB_AW'(r_col >> 1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_x[c]     = data_in[c*DATA_W +: DATA_W];
        assign w_x_ext[c] = PW'(w_x[c]);
        assign w_h_ext[c] = PW'(r_h[c]);

        pool_combine #(.DATA_W(DATA_W), .OUT_W(PW)) u_pair (
            .i_a       (w_h_ext[c]),
            .i_b       (w_x_ext[c]),
            .i_mode    (r_mode),
            .i_final   (1'b0),
            .i_relu_en (1'b0),
            .o_y       (w_p[c])
        );

        pool_combine #(.DATA_W(DATA_W), .OUT_W(DATA_W)) u_win (
            .i_a       (r_lb[c][w_lb_idx]),
            .i_b       (w_p[c]),
            .i_mode    (r_mode),
            .i_final   (1'b1),
            .i_relu_en (r_relu),
            .o_y       (w_w[c])
        );
    end

    // Counters, config latch, holding registers and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_mode     <= POOL_AVG;
            r_relu     <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_h[c] <= '0;
            end
        end else begin
            valid_out  <= w_fire;
            frame_done <= w_fire && w_col_last && w_row_last;
            if (valid_in) begin
                r_col <= w_col_last ? '0 : r_col + COL_BIT'(1);
                if (w_col_last) begin
                    r_row <= w_row_last ? '0 : r_row + ROW_BIT'(1);
                end
                // Config sampled on the first pixel holds for the whole frame.
                if (w_first) begin
                    r_mode <= mode;
                    r_relu <= relu_en;
                end
                for (int c = 0; c < CHANNELS; c++) begin
                    if (!r_col[0]) begin
                        r_h[c] <= w_x[c];
                    end
                    if (w_fire) begin
                        data_out[c*DATA_W +: DATA_W] <= w_w[c];
                    end
                end
            end
        end
    end

    // Line buffer carries no reset: each entry is written on an even row
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (!rst && valid_in && r_col[0] && !r_row[0]) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_lb[c][w_lb_idx] <= w_p[c];
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
module tb_pool2x2_stream;

    localparam int CH   = 2;
    localparam int DW   = 8;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int NPIX = IW * IH;
    localparam int NOUT = (IW / 2) * (IH / 2);
    localparam int NVEC = 5;

    typedef logic [NPIX-1:0][DW-1:0] v16_t;
    typedef logic [NOUT-1:0][DW-1:0] v4_t;

    typedef struct {
        v16_t px0;
        v16_t px1;
        logic md;
        logic re;
        v4_t  e0;
        v4_t  e1;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic [CH*DW-1:0]  data_in;
    logic              mode;
    logic              relu_en;
    logic [CH*DW-1:0]  data_out;
    logic              valid_out;
    logic              frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [CH*DW-1:0] q_dat [$];
    logic             q_fd  [$];
    int               q_cyc [$];
    int               exp_cyc [$];

    vec_t tv [NVEC];

    pool2x2_stream #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .IMG_W    (IW),
        .IMG_H    (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .mode       (mode),
        .relu_en    (relu_en),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            q_dat.push_back(data_out);
            q_fd.push_back(frame_done);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic v16_t mk_ramp(input int sgn, input bit rev);
        v16_t r;
        for (int i = 0; i < NPIX; i++) begin
            r[i] = DW'(sgn * (rev ? (NPIX - i) : (i + 1)));
        end
        return r;
    endfunction

    function automatic v4_t pk4(input int a, input int b, input int c, input int d);
        v4_t r;
        r[0] = DW'(a);
        r[1] = DW'(b);
        r[2] = DW'(c);
        r[3] = DW'(d);
        return r;
    endfunction

    task automatic clear_q();
        q_dat.delete();
        q_fd.delete();
        q_cyc.delete();
        exp_cyc.delete();
    endtask

    task automatic drive_px(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic m, input logic r, input bit win_last);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        data_in  = {b, a};
        mode     = m;
        relu_en  = r;
        if (win_last) exp_cyc.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            data_in  = CH*DW'($urandom);
        end
    endtask

    // Sends npx pixels of a frame; gapmax>0 inserts random bubbles; from
    // pixel toggle_at on the mode input is inverted.
    task automatic send_frame(input vec_t v, input int npx, input int gapmax, input int toggle_at);
        logic m;
        for (int i = 0; i < npx; i++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            m = (toggle_at >= 0 && i >= toggle_at) ? ~v.md : v.md;
            drive_px(v.px0[i], v.px1[i], m, v.re, ((i / IW) % 2 == 1) && (i % 2 == 1));
        end
    endtask

    task automatic check_frame(input v4_t e0, input v4_t e1, input int base,
                               input bit lat, input string tag);
        for (int k = 0; k < NOUT; k++) begin
            int idx;
            idx = base + k;
            if (idx >= q_dat.size()) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s out%0d: no output seen, expected one", tag, k);
            end else begin
                chk($sformatf("%s out%0d ch0", tag, k),
                    int'($signed(q_dat[idx][DW-1:0])), int'($signed(e0[k])));
                chk($sformatf("%s out%0d ch1", tag, k),
                    int'($signed(q_dat[idx][2*DW-1:DW])), int'($signed(e1[k])));
                chk($sformatf("%s out%0d frame_done", tag, k),
                    int'(q_fd[idx]), (k == NOUT - 1) ? 1 : 0);
                if (lat && idx < exp_cyc.size()) begin
                    chk($sformatf("%s out%0d latency cycle", tag, k), q_cyc[idx], exp_cyc[idx]);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = CH*DW'($urandom);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
    endtask

    initial begin
        int rnd [NPIX] = '{-128, -128, 127, 127,
                           -128, -127, 127, 127,
                             -1,   -1,  -2,  -2,
                             -1,   -2,  -2,  -1};
        vec_t f2;

        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        mode     = 1'b0;
        relu_en  = 1'b0;

        tv[0] = '{px0: mk_ramp(1, 0),  px1: mk_ramp(1, 1), md: 1'b0, re: 1'b0,
                  e0: pk4(4, 6, 12, 14),      e1: pk4(14, 12, 6, 4)};
        tv[1] = '{px0: mk_ramp(-1, 0), px1: mk_ramp(1, 0), md: 1'b1, re: 1'b1,
                  e0: pk4(0, 0, 0, 0),        e1: pk4(6, 8, 14, 16)};
        tv[2] = '{px0: mk_ramp(-1, 0), px1: mk_ramp(1, 0), md: 1'b1, re: 1'b0,
                  e0: pk4(-1, -3, -9, -11),   e1: pk4(6, 8, 14, 16)};
        tv[3] = '{px0: '0,             px1: mk_ramp(1, 0), md: 1'b0, re: 1'b0,
                  e0: pk4(-128, 127, -1, -2), e1: pk4(4, 6, 12, 14)};
        for (int i = 0; i < NPIX; i++) tv[3].px0[i] = DW'(rnd[i]);
        tv[4] = '{px0: mk_ramp(-1, 0), px1: mk_ramp(1, 0), md: 1'b0, re: 1'b1,
                  e0: pk4(0, 0, 0, 0),        e1: pk4(4, 6, 12, 14)};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset valid_out",  int'(valid_out), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset data_out",   int'(data_out), 0);

        // Table-driven frames, back to back through the counters' natural wrap.
        for (int t = 0; t < NVEC; t++) begin
            clear_q();
            send_frame(tv[t], NPIX, 0, -1);
            idle(3);
            chk($sformatf("vec%0d output count", t), q_dat.size(), NOUT);
            check_frame(tv[t].e0, tv[t].e1, 0, 1'b1, $sformatf("vec%0d", t));
        end

        // data_out holds its last value while valid_out is low.
        @(negedge clk);
        chk("hold valid_out low", int'(valid_out), 0);
        chk("hold data_out ch0", int'($signed(data_out[DW-1:0])), int'($signed(tv[NVEC-1].e0[3])));
        chk("hold data_out ch1", int'($signed(data_out[2*DW-1:DW])), int'($signed(tv[NVEC-1].e1[3])));

        // Random input gaps: same values, each output one cycle after its 4th pixel.
        clear_q();
        send_frame(tv[0], NPIX, 5, -1);
        idle(3);
        chk("stall output count", q_dat.size(), NOUT);
        check_frame(tv[0].e0, tv[0].e1, 0, 1'b1, "stall");

        // Reset after 6 pixels discards the partial frame.
        clear_q();
        send_frame(tv[0], 6, 0, -1);
        do_reset();
        @(negedge clk);
        chk("midreset valid_out", int'(valid_out), 0);
        chk("midreset data_out",  int'(data_out), 0);
        clear_q();
        send_frame(tv[0], NPIX, 0, -1);
        idle(3);
        chk("midreset output count", q_dat.size(), NOUT);
        check_frame(tv[0].e0, tv[0].e1, 0, 1'b1, "midreset");

        // Mode flipped mid-frame stays average; next frame (no bubble) is max.
        clear_q();
        f2    = tv[0];
        f2.md = 1'b1;
        f2.e0 = pk4(6, 8, 14, 16);
        f2.e1 = pk4(16, 14, 8, 6);
        send_frame(tv[0], NPIX, 0, 5);
        send_frame(f2, NPIX, 0, -1);
        idle(3);
        chk("modechg output count", q_dat.size(), 2 * NOUT);
        check_frame(tv[0].e0, tv[0].e1, 0, 1'b1, "modechg f1");
        check_frame(f2.e0, f2.e1, NOUT, 1'b1, "modechg f2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
